move_tracker: RTL and testbench

- Downstream consumer of the rat solver's `move[1:0]` stream.
- Replays each reported move from the start cell to reconstruct the rat's position.
- Range-checks every step, counts path length and buffers the moves for later readout.
- Issues a final verdict (reached goal / invalid / solver failed) once the solver raises `done` or `fail`.
- Sits between the solver top level and the display/host readout logic.

---
 rtl/move_tracker_pkg.sv | 17 +
 rtl/move_fifo.sv | 54 +++++
 rtl/move_tracker.sv | 135 +++++++++++++
 tb/tb_move_tracker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_tracker_pkg.sv
// Shared definitions for the rat solver and its downstream move tracker:
// the 2-bit move encoding and the tracker state encoding.
package move_tracker_pkg;

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FINISH = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO holding the accepted moves in order. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
// dout is registered and only changes on an accepted pop.
module move_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] dout_q;
    logic             do_push, do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = dout_q;

    // Pointer and read-data registers; flush empties without touching dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) begin
                dout_q <= mem_q[rd_q[AW-1:0]];
                rd_q   <= rd_q + 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/move_tracker.sv
// Replays the solver's move stream from (0,0), range-checks each step,
// counts accepted moves, buffers them for readout and issues a verdict
// once the solver reports done or fail.
module move_tracker
    import move_tracker_pkg::*;
#(
    parameter int N        = 4,
    parameter int DEPTH    = 256,
    parameter int LW       = 8,
    parameter int GOAL_ROW = 15,
    parameter int GOAL_COL = 15
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          run,
    input  logic          move_valid,
    input  logic [1:0]    move,
    input  logic          done_in,
    input  logic          fail_in,
    input  logic          rd_en,
    output logic [N-1:0]  row,
    output logic [N-1:0]  col,
    output logic [LW-1:0] path_len,
    output logic          busy,
    output logic          verdict_valid,
    output logic          goal_ok,
    output logic          bad_move,
    output logic [1:0]    rd_data,
    output logic          rd_empty
);
    localparam logic [N:0] ONE = (N+1)'(1);

    state_e        state_q;
    logic [N-1:0]  row_q, col_q;
    logic [LW-1:0] len_q;
    logic          busy_q, vv_q, goal_q, bad_q;

    logic [N:0]    row_d, col_d;
    logic          oob, len_max, step_err, at_goal;
    logic          fifo_full, fifo_push, fifo_pop;

    // Candidate post-move position, one bit wider so a step off either edge
    // shows up as the top bit (underflow wraps to all-ones, overflow carries).
    always_comb begin
        row_d = {1'b0, row_q};
        col_d = {1'b0, col_q};
        if (move_valid) begin
            case (move)
                MV_UP:    row_d = {1'b0, row_q} - ONE;
                MV_RIGHT: col_d = {1'b0, col_q} + ONE;
                MV_LEFT:  col_d = {1'b0, col_q} - ONE;
                MV_DOWN:  row_d = {1'b0, row_q} + ONE;
                default:  ;
            endcase
        end
    end

    assign oob       = row_d[N] | col_d[N];
    assign len_max   = &len_q;
    assign step_err  = move_valid && (oob || fifo_full || len_max);
    assign at_goal   = (row_d[N-1:0] == N'(GOAL_ROW)) && (col_d[N-1:0] == N'(GOAL_COL));
    assign fifo_push = (state_q == ST_TRACK) && !run && move_valid && !step_err;
    assign fifo_pop  = (state_q == ST_FINISH) && !run && rd_en;

    move_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (run),
        .din   (move),
        .full  (fifo_full),
        .empty (rd_empty),
        .dout  (rd_data)
    );

    // Tracker FSM with registered position, length and verdict flags;
    // run restarts from any state and overrides every other input.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            vv_q    <= 1'b0;
            goal_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else if (run) begin
            state_q <= ST_TRACK;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b1;
            vv_q    <= 1'b0;
            goal_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else if (state_q == ST_TRACK) begin
            if (step_err) begin
                // Position and length stay as they were before the bad step.
                state_q <= ST_ERROR;
                busy_q  <= 1'b0;
                vv_q    <= 1'b1;
                bad_q   <= 1'b1;
                goal_q  <= 1'b0;
            end else begin
                if (move_valid) begin
                    row_q <= row_d[N-1:0];
                    col_q <= col_d[N-1:0];
                    len_q <= len_q + LW'(1);
                end
                if (fail_in) begin
                    state_q <= ST_FINISH;
                    busy_q  <= 1'b0;
                    vv_q    <= 1'b1;
                    goal_q  <= 1'b0;
                end else if (done_in) begin
                    state_q <= ST_FINISH;
                    busy_q  <= 1'b0;
                    vv_q    <= 1'b1;
                    goal_q  <= at_goal;
                end
            end
        end
    end

    assign row           = row_q;
    assign col           = col_q;
    assign path_len      = len_q;
    assign busy          = busy_q;
    assign verdict_valid = vv_q;
    assign goal_ok       = goal_q;
    assign bad_move      = bad_q;

endmodule

// File: tb/tb_move_tracker.sv
// Directed bench for move_tracker: a behavioural model (queue of moves,
// integer position) is compared against the DUT every cycle, plus literal
// expectations at the interesting points of each scenario.
module tb_move_tracker;
    localparam int N = 4, DEPTH = 32, LW = 8;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          run = 1'b0, move_valid = 1'b0, done_in = 1'b0, fail_in = 1'b0, rd_en = 1'b0;
    logic [1:0]    move = 2'b00;
    logic [N-1:0]  row, col;
    logic [LW-1:0] path_len;
    logic          busy, verdict_valid, goal_ok, bad_move, rd_empty;
    logic [1:0]    rd_data;

    int checks = 0, failures = 0;

    move_tracker #(.N(N), .DEPTH(DEPTH), .LW(LW), .GOAL_ROW(15), .GOAL_COL(15)) dut (
        .clk(clk), .RST(RST), .run(run), .move_valid(move_valid), .move(move),
        .done_in(done_in), .fail_in(fail_in), .rd_en(rd_en),
        .row(row), .col(col), .path_len(path_len), .busy(busy),
        .verdict_valid(verdict_valid), .goal_ok(goal_ok), .bad_move(bad_move),
        .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 tracking, 2 finished, 3 error
    int         m_mode = 0, m_row = 0, m_col = 0, m_len = 0;
    bit         m_goal = 0, m_bad = 0, m_vv = 0;
    logic [1:0] m_rd = 2'b00;
    logic [1:0] m_q [$];

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            m_mode = 0; m_row = 0; m_col = 0; m_len = 0;
            m_goal = 0; m_bad = 0; m_vv = 0; m_rd = 2'b00;
            m_q.delete();
        end else if (run) begin
            m_mode = 1; m_row = 0; m_col = 0; m_len = 0;
            m_goal = 0; m_bad = 0; m_vv = 0;
            m_q.delete();
        end else if (m_mode == 1) begin
            int nr, nc;
            bit err;
            err = 0;
            if (move_valid) begin
                nr = m_row; nc = m_col;
                case (move)
                    2'b00: nr = nr - 1;
                    2'b01: nc = nc + 1;
                    2'b10: nc = nc - 1;
                    default: nr = nr + 1;
                endcase
                if (nr < 0 || nr > 15 || nc < 0 || nc > 15 ||
                    m_q.size() >= DEPTH || m_len + 1 >= (1 << LW)) err = 1;
                if (err) begin
                    m_mode = 3; m_bad = 1; m_vv = 1; m_goal = 0;
                end else begin
                    m_row = nr; m_col = nc; m_len++;
                    m_q.push_back(move);
                end
            end
            if (!err && (fail_in || done_in)) begin
                m_mode = 2; m_vv = 1;
                m_goal = !fail_in && m_row == 15 && m_col == 15;
            end
        end else if (m_mode == 2 && rd_en && m_q.size() > 0) begin
            m_rd = m_q.pop_front();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checks++;
        if (row !== m_row[N-1:0] || col !== m_col[N-1:0] || path_len !== m_len[LW-1:0] ||
            busy !== (m_mode == 1) || verdict_valid !== m_vv || goal_ok !== m_goal ||
            bad_move !== m_bad || rd_data !== m_rd || rd_empty !== (m_q.size() == 0)) begin
            failures++;
            $display("FAIL model_cmp t=%0t dut row=%0d col=%0d len=%0d busy=%b vv=%b goal=%b bad=%b rd=%b empty=%b | model row=%0d col=%0d len=%0d busy=%b vv=%b goal=%b bad=%b rd=%b empty=%b",
                     $time, row, col, path_len, busy, verdict_valid, goal_ok, bad_move, rd_data, rd_empty,
                     m_row, m_col, m_len, m_mode == 1, m_vv, m_goal, m_bad, m_rd, m_q.size() == 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, return at posedge+1 with inputs idle.
    task automatic step(input logic mv, input logic [1:0] m, input logic dn, input logic fl,
                        input logic rn, input logic rd);
        move_valid = mv; move = m; done_in = dn; fail_in = fl; run = rn; rd_en = rd;
        @(posedge clk); #1;
        move_valid = 0; move = 2'b00; done_in = 0; fail_in = 0; run = 0; rd_en = 0;
    endtask

    task automatic mv(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) step(1, m, 0, 0, 0, 0);
    endtask

    task automatic start();
        step(0, 2'b00, 0, 0, 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 RST = 1'b0;
        #20 RST = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_row", row, 0);
        chk("rst_len", path_len, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_vv", verdict_valid, 0);

        // IDLE ignores moves and done
        step(1, 2'b01, 1, 0, 0, 0);
        chk("idle_col", col, 0);
        chk("idle_vv", verdict_valid, 0);

        // Goal path: 15 right, 15 down, done
        start();
        chk("run_busy", busy, 1);
        mv(2'b01, 15);
        mv(2'b11, 15);
        step(0, 2'b00, 1, 0, 0, 0);
        chk("goal_row", row, 15);
        chk("goal_col", col, 15);
        chk("goal_len", path_len, 30);
        chk("goal_ok", goal_ok, 1);
        chk("goal_vv", verdict_valid, 1);
        chk("goal_busy", busy, 0);
        for (int i = 0; i < 30; i++) begin
            step(0, 2'b00, 0, 0, 0, 1);
            chk($sformatf("goal_rd%0d", i), rd_data, (i < 15) ? 2'b01 : 2'b11);
        end
        chk("goal_empty", rd_empty, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        chk("rd_empty_hold", rd_data, 2'b11);

        // Out of bounds: one right, then up at row 0
        start();
        mv(2'b01, 1);
        mv(2'b00, 1);
        chk("oob_bad", bad_move, 1);
        chk("oob_vv", verdict_valid, 1);
        chk("oob_row", row, 0);
        chk("oob_col", col, 1);
        chk("oob_len", path_len, 1);
        step(1, 2'b01, 0, 0, 0, 1);
        chk("err_rd_hold", rd_data, 2'b11);
        chk("err_not_empty", rd_empty, 0);
        chk("err_col_frozen", col, 1);

        // Out of bounds at the far edge: down at row 15
        start();
        mv(2'b11, 15);
        mv(2'b11, 1);
        chk("oob_down_bad", bad_move, 1);
        chk("oob_down_row", row, 15);

        // Solver fail with a same-cycle 4th move and done (fail wins)
        start();
        mv(2'b01, 3);
        step(1, 2'b01, 1, 1, 0, 0);
        chk("fail_col", col, 4);
        chk("fail_len", path_len, 4);
        chk("fail_goal", goal_ok, 0);
        chk("fail_vv", verdict_valid, 1);

        // Done away from the goal
        start();
        step(0, 2'b00, 1, 0, 0, 0);
        chk("done_nogoal", goal_ok, 0);
        chk("done_nogoal_vv", verdict_valid, 1);

        // Buffer overflow: DEPTH moves fill it, the next one errors
        start();
        for (int i = 0; i < DEPTH; i++) mv((i % 2 == 0) ? 2'b01 : 2'b10, 1);
        chk("full_len", path_len, DEPTH);
        chk("full_busy", busy, 1);
        mv(2'b01, 1);
        chk("ovf_bad", bad_move, 1);
        chk("ovf_len", path_len, DEPTH);
        chk("ovf_col", col, 0);

        // Move and done together landing on the goal
        start();
        mv(2'b11, 15);
        mv(2'b01, 14);
        step(1, 2'b01, 1, 0, 0, 0);
        chk("sim_goal", goal_ok, 1);
        chk("sim_col", col, 15);
        chk("sim_len", path_len, 30);

        // Async reset mid-trace
        start();
        mv(2'b01, 5);
        chk("pre_rst_col", col, 5);
        #1 RST = 1'b0;
        #1;
        chk("arst_col", col, 0);
        chk("arst_len", path_len, 0);
        chk("arst_busy", busy, 0);
        chk("arst_empty", rd_empty, 1);
        #1 RST = 1'b1;
        step(1, 2'b01, 0, 0, 0, 0);
        chk("post_rst_idle_col", col, 0);
        chk("post_rst_idle_busy", busy, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
